// File: rtl/w5300_bus_arbiter.sv
// Shares one W5300 host interface between NUM_REQ requesters. Requester 0 (IRQ
// handler) always wins arbitration; the others are served round-robin with burst limits.
//
// state | meaning
// IDLE  | no owner, arbitrating among asserted req lines
// OWNED | gnt held by owner, waiting for its start strobe
// BUSY  | access in flight at the interface, waiting for if_done or timeout
module w5300_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 64,
    parameter int TIMEOUT   = 6000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      start,
    input  logic [NUM_REQ*11-1:0]   req_addr,
    input  logic [NUM_REQ*16-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [15:0]             rd_data,
    output logic [10:0]             if_addr,
    output logic [15:0]             if_wr_data,
    output logic                    if_start,
    input  logic                    if_done,
    input  logic [15:0]             if_rd_data,
    output logic                    timeout_err
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_OWNED, S_BUSY} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        owner, owner_nxt, last, last_nxt, win, idx;
    logic                 found;
    logic [NUM_REQ-1:0]   owner_oh, win_oh, gnt_nxt, done_nxt;
    logic [BW-1:0]        burst_cnt, burst_nxt, burst_inc;
    logic [TW-1:0]        tmr, tmr_nxt;
    logic [15:0]          rd_data_nxt, if_wr_data_nxt;
    logic [10:0]          if_addr_nxt;
    logic                 if_start_nxt, timeout_err_nxt, others_req, release_bus;

    // Requester 0 has absolute priority; otherwise search starts after the last owner.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        if (req[0]) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = IW'((int'(last) + k) % NUM_REQ);
                if (!found && req[idx]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        win_oh        = '0;
        win_oh[win]   = 1'b1;
        owner_oh      = '0;
        owner_oh[owner] = 1'b1;
        others_req    = |(req & ~owner_oh);
    end

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        last_nxt        = last;
        gnt_nxt         = gnt;
        burst_nxt       = burst_cnt;
        tmr_nxt         = tmr;
        done_nxt        = '0;
        if_start_nxt    = 1'b0;
        rd_data_nxt     = rd_data;
        if_addr_nxt     = if_addr;
        if_wr_data_nxt  = if_wr_data;
        timeout_err_nxt = timeout_err;
        burst_inc       = burst_cnt + 1'b1;
        release_bus     = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    gnt_nxt   = win_oh;
                    owner_nxt = win;
                    last_nxt  = win;
                    burst_nxt = '0;
                    state_nxt = S_OWNED;
                end
            end
            S_OWNED: begin
                if (!req[owner]) begin
                    gnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (start[owner]) begin
                    if_addr_nxt    = req_addr[int'(owner)*11 +: 11];
                    if_wr_data_nxt = req_wr_data[int'(owner)*16 +: 16];
                    if_start_nxt   = 1'b1;
                    tmr_nxt        = TW'(TIMEOUT);
                    state_nxt      = S_BUSY;
                end
            end
            S_BUSY: begin
                if (if_done) begin
                    rd_data_nxt = if_rd_data;
                    done_nxt    = owner_oh;
                    // A pending IRQ requester takes the bus at the first completion.
                    release_bus = !req[owner]
                                || (burst_inc == BW'(MAX_BURST) && others_req)
                                || (req[0] && owner != '0);
                    if (release_bus) begin
                        gnt_nxt   = '0;
                        burst_nxt = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        burst_nxt = (burst_inc == BW'(MAX_BURST)) ? '0 : burst_inc;
                        state_nxt = S_OWNED;
                    end
                end else if (tmr == '0) begin
                    timeout_err_nxt = 1'b1;
                    rd_data_nxt     = 16'hFFFF;
                    done_nxt        = owner_oh;
                    state_nxt       = S_OWNED;
                end else begin
                    tmr_nxt = tmr - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            owner       <= '0;
            last        <= '0;
            gnt         <= '0;
            burst_cnt   <= '0;
            tmr         <= '0;
            done        <= '0;
            if_start    <= 1'b0;
            rd_data     <= '0;
            if_addr     <= {1'b1, 10'h3FE};
            if_wr_data  <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last        <= last_nxt;
            gnt         <= gnt_nxt;
            burst_cnt   <= burst_nxt;
            tmr         <= tmr_nxt;
            done        <= done_nxt;
            if_start    <= if_start_nxt;
            rd_data     <= rd_data_nxt;
            if_addr     <= if_addr_nxt;
            if_wr_data  <= if_wr_data_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Scoreboard bench for w5300_bus_arbiter: requesters and a W5300 responder are modelled
// here; expected launches/completions are queued at issue time and checked by a monitor.
module tb_w5300_bus_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int MAX_BURST = 4;
    localparam int TIMEOUT   = 20;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req = '0;
    logic [NUM_REQ-1:0]    start = '0;
    logic [NUM_REQ*11-1:0] req_addr = '0;
    logic [NUM_REQ*16-1:0] req_wr_data = '0;
    logic [NUM_REQ-1:0]    gnt, done;
    logic [15:0]           rd_data, if_wr_data;
    logic [15:0]           if_rd_data = '0;
    logic [10:0]           if_addr;
    logic                  if_start, timeout_err;
    logic                  if_done = 1'b0;

    int checks = 0;
    int failures = 0;

    typedef struct {logic [10:0] addr; logic [15:0] wdata;} launch_t;
    typedef struct {int owner; logic [15:0] data;} done_t;
    typedef struct {int delay; logic [15:0] data; bit withhold; bit abort;} resp_t;

    launch_t exp_launch[$];
    done_t   exp_done[$];
    resp_t   resp_q[$];
    int      got_grants[$];
    int      exp_grants[$];
    logic [NUM_REQ-1:0] prev_gnt = '0;

    w5300_bus_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .start(start), .req_addr(req_addr),
        .req_wr_data(req_wr_data), .gnt(gnt), .done(done), .rd_data(rd_data),
        .if_addr(if_addr), .if_wr_data(if_wr_data), .if_start(if_start),
        .if_done(if_done), .if_rd_data(if_rd_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arbitration rule: IRQ requester first, else first asserted after last owner.
    function automatic int next_owner(input logic [NUM_REQ-1:0] r, input int last_own);
        if (r[0]) return 0;
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last_own + k) % NUM_REQ]) return (last_own + k) % NUM_REQ;
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic reset_values(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_if_start"}, 32'(if_start), 32'd0);
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_if_addr"}, 32'(if_addr), 32'h7FE);
        check({tag, "_if_wr_data"}, 32'(if_wr_data), 32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT launches or completes an access.
    always @(negedge clk) begin
        launch_t l;
        done_t   e;
        if (rst_n) begin
            check("gnt_onehot", 32'(gnt & (gnt - 1'b1)), 32'd0);
            if (gnt != '0 && gnt != prev_gnt) got_grants.push_back(onehot_idx(gnt));
            if (if_start) begin
                if (exp_launch.size() == 0) check("unexpected_if_start", 32'(if_start), 32'd0);
                else begin
                    l = exp_launch.pop_front();
                    check("if_addr", 32'(if_addr), 32'(l.addr));
                    check("if_wr_data", 32'(if_wr_data), 32'(l.wdata));
                end
            end
            if (done != '0) begin
                if (exp_done.size() == 0) check("unexpected_done", 32'(done), 32'd0);
                else begin
                    e = exp_done.pop_front();
                    check("done_owner", 32'(done), 32'd1 << e.owner);
                    check("rd_data", 32'(rd_data), 32'(e.data));
                end
            end
        end
        prev_gnt = gnt;
    end

    // W5300 interface model: answers each launch as scripted by the issuing driver.
    initial begin : responder
        resp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && if_start) begin
                if (resp_q.size() == 0) check("resp_underflow", 32'(if_start), 32'd0);
                else begin
                    r = resp_q.pop_front();
                    if (r.withhold) begin
                        repeat (TIMEOUT) @(posedge clk);
                        @(negedge clk);
                        check("timeout_not_early", 32'(done), 32'd0);
                        @(negedge clk);
                        check("timeout_done", 32'(|done), 32'd1);
                        check("timeout_err_set", 32'(timeout_err), 32'd1);
                    end else begin
                        repeat (r.delay) @(posedge clk);
                        #1 if_done = 1'b1;
                        if_rd_data = r.data;
                        @(posedge clk);
                        #1 if_done = 1'b0;
                        if_rd_data = 16'($urandom);
                        if (!r.abort) begin
                            @(negedge clk);
                            check("done_latency", 32'(|done), 32'd1);
                        end
                    end
                end
            end
        end
    end

    // mode 0: normal, 1: responder withholds if_done, 2: access aborted by reset
    task automatic do_access(input int i, input int mode, input int delay, input logic [10:0] a,
                             input logic [15:0] d, input logic [15:0] r, output bit ok);
        launch_t l;
        done_t   e;
        resp_t   rs;
        int      n;
        ok = 1'b0;
        n = 0;
        while (gnt[i] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check($sformatf("gnt_wait_%0d", i), 32'(gnt[i]), 32'd1);
        if (gnt[i] !== 1'b1) return;
        @(posedge clk);
        #1;
        req_addr[i*11 +: 11]    = a;
        req_wr_data[i*16 +: 16] = d;
        start[i] = 1'b1;
        l.addr = a; l.wdata = d;
        exp_launch.push_back(l);
        rs.delay = delay; rs.data = r; rs.withhold = (mode == 1); rs.abort = (mode == 2);
        resp_q.push_back(rs);
        if (mode != 2) begin
            e.owner = i;
            e.data  = (mode == 1) ? 16'hFFFF : r;
            exp_done.push_back(e);
        end
        @(posedge clk);
        #1 start[i] = 1'b0;
        @(negedge clk);
        check("launch_latency", 32'(if_start), 32'd1);
        if (mode == 2) begin ok = 1'b1; return; end
        n = 0;
        while (done[i] !== 1'b1 && n < TIMEOUT + 20) begin @(negedge clk); n++; end
        check($sformatf("done_seen_%0d", i), 32'(done[i]), 32'd1);
        ok = (done[i] === 1'b1);
    endtask

    task automatic rand_access(input int i, input int delay);
        logic [10:0] a;
        logic [15:0] d, r;
        bit ok;
        a = 11'($urandom); d = 16'($urandom); r = 16'($urandom);
        do_access(i, 0, delay, a, d, r, ok);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [10:0] a;
        logic [15:0] d, r;
        logic [NUM_REQ-1:0] mask;
        bit ok;
        int own, cnt, last_m, kk, n, seen;

        @(negedge clk);
        reset_values("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // First grant latency and basic read through requester 1
        @(posedge clk);
        #1 req = 4'b0010;
        @(negedge clk);
        check("gnt_before_edge", 32'(gnt), 32'd0);
        @(negedge clk);
        check("gnt_latency", 32'(gnt), 32'b0010);
        do_access(1, 0, 2, 11'h400, 16'hABCD, 16'h5300, ok);
        check("rd_data_5300", 32'(rd_data), 32'h5300);

        // Start from a non-owner must be ignored
        @(posedge clk);
        #1 req_addr[3*11 +: 11] = 11'h155;
        start[3] = 1'b1;
        @(posedge clk);
        #1 start[3] = 1'b0;
        @(negedge clk);
        check("nonowner_no_if_start", 32'(if_start), 32'd0);
        @(negedge clk);
        check("nonowner_gnt_kept", 32'(gnt), 32'b0010);
        rand_access(1, 3);

        // IRQ requester rises while owner 2 is busy
        req = 4'b0100;
        a = 11'($urandom); d = 16'($urandom); r = 16'($urandom);
        fork
            do_access(2, 0, 4, a, d, r, ok);
            begin
                n = 0;
                while (if_start !== 1'b1 && n < 60) begin @(negedge clk); n++; end
                req[0] = 1'b1;
            end
        join
        n = 0;
        while (gnt !== 4'b0001 && n < 2) begin @(negedge clk); n++; end
        check("req0_wins", 32'(gnt), 32'b0001);
        rand_access(0, 2);
        req[0] = 1'b0;
        own = next_owner(req, 0);
        rand_access(own, 1);

        // if_done on the expiry cycle is a normal completion
        a = 11'($urandom); d = 16'($urandom); r = 16'($urandom);
        do_access(2, 0, TIMEOUT, a, d, r, ok);
        check("boundary_no_timeout", 32'(timeout_err), 32'd0);
        check("boundary_rd_data", 32'(rd_data), 32'(r));

        // Withheld completion -> timeout, then normal operation continues
        do_access(2, 1, 0, a, d, r, ok);
        check("timeout_rd_data", 32'(rd_data), 32'hFFFF);
        check("timeout_err_flag", 32'(timeout_err), 32'd1);
        rand_access(2, 2);
        check("timeout_err_sticky", 32'(timeout_err), 32'd1);

        @(posedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        reset_values("idle_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin bursts with three contenders
        got_grants.delete();
        exp_grants.delete();
        req = 4'b1110;
        own = next_owner(req, 0);
        cnt = 0;
        exp_grants.push_back(own);
        for (int k = 0; k < 4*MAX_BURST; k++) begin
            rand_access(own, int'($urandom_range(1, 4)));
            cnt++;
            if (cnt == MAX_BURST) begin
                cnt = 0;
                if (k != 4*MAX_BURST - 1 && (req & ~(4'b0001 << own)) != '0) begin
                    own = next_owner(req, own);
                    exp_grants.push_back(own);
                end
            end
        end
        req = '0;
        repeat (2) @(negedge clk);
        check("grant_count", 32'(got_grants.size()), 32'(exp_grants.size()));
        for (int k = 0; k < exp_grants.size(); k++)
            if (k < got_grants.size())
                check($sformatf("grant_order_%0d", k), 32'(got_grants[k]), 32'(exp_grants[k]));

        // Random request masks, short bursts
        last_m = onehot_idx(4'b0010);
        for (int it = 0; it < 20; it++) begin
            req = '0;
            repeat (2) @(negedge clk);
            mask = 4'($urandom_range(1, 15));
            req = mask;
            own = next_owner(mask, last_m);
            kk = int'($urandom_range(1, MAX_BURST - 1));
            for (int j = 0; j < kk; j++) rand_access(own, int'($urandom_range(1, 4)));
            last_m = own;
        end

        // Reset in the middle of an access
        req = '0;
        repeat (2) @(negedge clk);
        req = 4'b0010;
        a = 11'($urandom); d = 16'($urandom); r = 16'($urandom);
        do_access(1, 2, 6, a, d, r, ok);
        @(posedge clk);
        #1 rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        reset_values("busy_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (done != '0 || gnt != '0 || if_start) seen++;
        end
        check("quiet_after_reset", 32'(seen), 32'd0);

        check("launch_q_empty", 32'(exp_launch.size()), 32'd0);
        check("done_q_empty", 32'(exp_done.size()), 32'd0);
        check("resp_q_empty", 32'(resp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w5300_bus_arbiter.md
W5300_BUS_ARBITER -- requirements
Module: w5300_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters; index 0 is the IRQ handler and is urgent.
REQ-002 SHALL have parameter MAX_BURST, default 64: maximum completed accesses per grant while others are waiting.
REQ-003 SHALL have parameter TIMEOUT, default 6000: clk cycles allowed from if_start to if_done.
REQ-004 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, NUM_REQ: level request; held high for the whole burst.
REQ-007 SHALL have port start, input, NUM_REQ: one-cycle access strobe from a requester.
REQ-008 SHALL have port req_addr, input, NUM_REQ*11: per-requester {rd/wr flag, addr[9:0]}, slice i = bits [11i+10:11i].
REQ-009 SHALL have port req_wr_data, input, NUM_REQ*16: per-requester write data, slice i = bits [16i+15:16i].
REQ-010 SHALL have port gnt, output, NUM_REQ: one-hot or zero ownership indication.
REQ-011 SHALL have port done, output, NUM_REQ: one-cycle access-complete pulse to the owner.
REQ-012 SHALL have port rd_data, output, 16: read data captured at completion, shared by all requesters.
REQ-013 SHALL have port if_addr, output, 11: address and flag to w5300_interface.
REQ-014 SHALL have port if_wr_data, output, 16: write data to w5300_interface.
REQ-015 SHALL have port if_start, output, 1: one-cycle access launch to w5300_interface.
REQ-016 SHALL have port if_done, input, 1: one-cycle completion from w5300_interface.
REQ-017 SHALL have port if_rd_data, input, 16: read data from w5300_interface, valid with if_done.
REQ-018 SHALL have port timeout_err, output, 1: sticky flag set by an access timeout.

Function
REQ-019 SHALL implement an FSM with states IDLE, OWNED and BUSY.
REQ-020 In IDLE with any req high, SHALL register a one-hot gnt the next cycle and enter OWNED, giving a grant latency of exactly 1 cycle.
REQ-021 Arbitration SHALL grant req[0] whenever it is high; otherwise it SHALL grant round-robin, starting the search at the index after the last owner (index 1 after reset).
REQ-022 In OWNED, start[owner] SHALL latch that requester's addr/wr_data into if_addr/if_wr_data, pulse if_start on the next cycle, and move to BUSY.
REQ-023 Start from any non-owner, or in any state other than OWNED, SHALL be ignored; no side effects.
REQ-024 In BUSY, if_done SHALL capture if_rd_data into rd_data and pulse done[owner] on the next cycle.
REQ-025 On each if_done, the burst counter SHALL increment; the counter is 0 at each new grant.
REQ-026 After a completion, SHALL return to OWNED if req[owner] is high, unless burst count = MAX_BURST and another req is high.
REQ-027 In the MAX_BURST-with-other-requester case, SHALL drop gnt and re-arbitrate through IDLE.
REQ-028 At MAX_BURST with no other requester, the counter SHALL clear and ownership SHALL continue.
REQ-029 A req[owner] drop in OWNED SHALL clear gnt the next cycle and return to IDLE.
REQ-030 A req[owner] drop in BUSY SHALL let the access finish, still pulse done, then go to IDLE.
REQ-031 req[0] rising during another owner's burst SHALL NOT preempt an access in flight; req[0] SHALL win at the next arbitration point.
REQ-032 The timeout counter SHALL run only in BUSY; when it reaches TIMEOUT with no if_done, SHALL set timeout_err, pulse done[owner] with rd_data=16'hFFFF, and return to OWNED.
REQ-033 if_done received outside BUSY SHALL be ignored.
REQ-034 if_done on the cycle the timeout expires SHALL count as a normal completion; timeout_err SHALL stay 0.
REQ-035 if_start SHALL never pulse while in BUSY; at most one access is in flight.

Reset
REQ-036 On rst_n low, SHALL go to IDLE and clear gnt, done, if_start, timeout_err, the counters and the RR pointer.
REQ-037 Reset values SHALL be rd_data=0, if_addr={1'b1,10'h3FE} (idle read) and if_wr_data=0.
REQ-038 Reset asserted mid-BUSY SHALL abort immediately, with no done pulse after release.
REQ-039 timeout_err SHALL clear only on reset.

Verification
REQ-040 Bench SHALL cover: req=4'b0010 at cycle 0 -> gnt=4'b0010 at cycle 1; start[1] with addr 11'h400 -> if_start next cycle, if_addr=11'h400; if_done with data 16'h5300 -> done[1] and rd_data=16'h5300 the next cycle.
REQ-041 Bench SHALL cover: req=4'b1110 held with continuous starts -> grant order 1,2,3,1, each burst of exactly MAX_BURST accesses.
REQ-042 Bench SHALL cover: owner 2 BUSY, req[0] rises -> owner 2's access completes, then gnt=4'b0001 after at most 2 cycles even though req[2] stays high.
REQ-043 Bench SHALL cover: if_done withheld -> after TIMEOUT cycles, timeout_err=1, done[owner] pulses, rd_data=16'hFFFF, and the arbiter keeps operating.
REQ-044 Bench SHALL cover: start[3] while gnt=4'b0010 -> no if_start; gnt[1]'s following start is serviced normally.
REQ-045 Bench SHALL cover: rst_n low during BUSY -> all outputs take reset values; no done pulse for 10 cycles after release with req=0.
